shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin a multiplication; sampled only when idle.
REQ-005 SHALL provide port signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; captured with the operands.
REQ-006 SHALL provide port a  input  WIDTH  multiplicand.
REQ-007 SHALL provide port b  input  WIDTH  multiplier.
REQ-008 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse marking a new valid result on s.
REQ-010 SHALL provide port s  output  2*WIDTH  product; held until the next done pulse.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 IDLE: on an edge with start=1, SHALL capture a, b and signed_mode, clear the accumulator and the iteration counter, enter RUN, and set busy=1.
REQ-013 Signed capture: SHALL store the operand magnitudes and the result sign (sign(a) XOR sign(b)); unsigned capture: SHALL store the operands unchanged with a positive sign.
REQ-014 RUN: SHALL perform exactly one shift-add iteration per clock, i.e. if the current multiplier bit is 1, add the multiplicand shifted left by the counter value to the 2*WIDTH-bit accumulator; then increment the counter.
REQ-015 After the WIDTH-th iteration edge, SHALL go to IDLE, set busy=0, assign s from the accumulator (two's-complement negated when the stored sign is negative), and set done=1 for that one cycle only.
REQ-016 Latency: done SHALL rise exactly WIDTH+1 rising edges after the edge that sampled start.
REQ-017 start while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-018 Changes to a, b or signed_mode during RUN SHALL NOT affect the in-flight result.
REQ-019 start=1 during the done cycle SHALL be accepted (back-to-back operation; one result every WIDTH+1 cycles).
REQ-020 The product SHALL be exact over the full operand range: unsigned 0..(2^WIDTH-1)^2; signed including (-2^(WIDTH-1))*(-2^(WIDTH-1)) = +2^(2*WIDTH-2), which fits in 2*WIDTH signed bits.
REQ-021 A zero operand SHALL still take the full WIDTH+1-cycle latency and produce s=0 (no early termination).
REQ-022 done and busy SHALL never both be 1 in the same cycle.

Reset
REQ-023 rst=1 on an edge SHALL force: state IDLE, busy=0, done=0, s=0, counter=0, accumulator=0.
REQ-024 rst SHALL take priority over start and over any RUN iteration on the same edge.
REQ-025 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-026 The first edge with rst=0 and start=1 SHALL start a new operation normally.

Verification
REQ-027 Exhaustive WIDTH=4 unsigned: all 256 (a,b) pairs, one per operation -> s == a*b at every done; e.g. 15*15 -> s=8'd225.
REQ-028 Exhaustive WIDTH=4 signed: all 256 pairs -> s == signed product; e.g. -8*-8 -> 8'sd64; -8*7 -> 8'b1100_1000 (-56); 7*-1 -> 8'b1111_1001 (-7).
REQ-029 Latency/handshake: start at edge 0 with a=3, b=5 (WIDTH=4) -> busy=1 during cycles 1..4, done=1 only in cycle 5, s=15 from cycle 5; a second start on the done cycle -> next done at cycle 10.
REQ-030 Start during busy: a=2, b=3, then start with a=9, b=9 two cycles later -> single done, s=6; busy timing unchanged.
REQ-031 Reset mid-operation: rst asserted in cycle 2 of RUN -> busy=0, s=0, no done pulse; a fresh start with a=4, b=4 -> done after WIDTH+1 edges, s=16.
REQ-032 WIDTH=8 corners: unsigned 255*255 -> s=65025; signed -128*-128 -> 16384; signed -128*127 -> -16256; 0*200 -> 0 with a 9-edge latency.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, with unsigned
// or two's-complement operands handled by sign-magnitude conversion.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] s
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 last;

  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand_sh;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return -v;
    end
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic is_neg);
    logic signed [2*WIDTH-1:0] smag;
    smag = signed'(mag);
    if (is_neg) begin
      smag = -smag;
    end
    return unsigned'(smag);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign acc_nxt = mplier[0] ? (acc + mcand_sh) : acc;

  // Capture stage on accept, iteration stage while running; the final
  // iteration also writes the signed result so done lands on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mcand_sh <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      s        <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt      <= '0;
        mcand_sh <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
        mplier   <= magnitude(b, signed_mode);
        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc      <= '0;
      end else if (state == RUN) begin
        acc      <= acc_nxt;
        mcand_sh <= mcand_sh << 1;
        mplier   <= mplier >> 1;
        cnt      <= cnt + CNT_W'(1);
        if (last) begin
          s <= apply_sign(acc_nxt, neg);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
// Cycle k is the clock period ending at edge k; start is sampled at edge 0.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        mon_en = 1'b0;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  s4;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] s8;

  int checks = 0;
  int errors = 0;
  int cyc;
  int extra;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .s(s4)
  );

  shift_add_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .s(s8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (!(busy4 && done4) && !(busy8 && done8)) else begin
        errors++;
        $error("FAIL busy_done_overlap observed=%b%b/%b%b expected=not both",
               busy4, done4, busy8, done8);
      end
    end
  end

  task automatic go4(input logic [3:0] av, input logic [3:0] bv, input logic sm);
    a4 = av; b4 = bv; sm4 = sm; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 1;
  endtask

  task automatic wait4(input string tag);
    while (!done4 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, done4, 1'b1);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                      input logic [7:0] exp, input string tag);
    go4(av, bv, sm);
    a4 = ~av; b4 = av ^ bv ^ 4'h5; sm4 = ~sm;
    wait4(tag);
    chk({tag, "_s"}, s4, exp);
    chk({tag, "_cycle"}, cyc, 5);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                      input logic [15:0] exp, input string tag);
    a8 = av; b8 = bv; sm8 = sm; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; sm8 = ~sm;
    cyc = 1;
    while (!done8 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, done8, 1'b1);
    chk({tag, "_s"}, s8, exp);
    chk({tag, "_cycle"}, cyc, 9);
  endtask

  initial begin
    logic signed [7:0] sp;
    rst = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) tick();
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_s4", s4, 8'd0);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_s8", s8, 16'd0);

    // reset wins over start on the same edge
    a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    tick();
    chk("rst_over_start_busy", busy4, 1'b0);
    start4 = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // handshake timing: 3*5, then back-to-back start in the done cycle
    go4(4'd3, 4'd5, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("hs_busy", busy4, 1'b1);
      chk("hs_nodone", done4, 1'b0);
      tick();
      cyc++;
    end
    chk("hs_done_c5", done4, 1'b1);
    chk("hs_busy_c5", busy4, 1'b0);
    chk("hs_s", s4, 8'd15);
    go4(4'd6, 4'd7, 1'b0);
    chk("hs_done_c6", done4, 1'b0);
    chk("hs_s_held", s4, 8'd15);
    wait4("b2b");
    chk("b2b_cycle", 5 + cyc, 10);
    chk("b2b_s", s4, 8'd42);

    // start while busy is ignored
    go4(4'd2, 4'd3, 1'b0);
    tick(); cyc++;
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    tick(); cyc++;
    start4 = 1'b0;
    chk("ign_busy", busy4, 1'b1);
    wait4("ign");
    chk("ign_cycle", cyc, 5);
    chk("ign_s", s4, 8'd6);
    extra = 0;
    repeat (8) begin
      tick();
      if (done4) extra++;
    end
    chk("ign_single_done", extra, 0);
    chk("ign_idle", busy4, 1'b0);

    // reset during run aborts without a done pulse
    go4(4'd5, 4'd7, 1'b0);
    tick(); cyc++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_s", s4, 8'd0);
    chk("abort_done", done4, 1'b0);
    extra = 0;
    repeat (8) begin
      tick();
      if (done4) extra++;
    end
    chk("abort_no_done", extra, 0);
    run4(4'd4, 4'd4, 1'b0, 8'd16, "after_rst");

    // directed WIDTH=4 vectors
    run4(4'd15, 4'd15, 1'b0, 8'd225, "u15x15");
    run4(4'd13, 4'd6,  1'b0, 8'd78,  "u13x6");
    run4(4'd9,  4'd1,  1'b0, 8'd9,   "u9x1");
    run4(4'd0,  4'd0,  1'b0, 8'd0,   "u0x0");
    run4(4'h8,  4'h8,  1'b1, 8'h40,  "sm8xm8");
    run4(4'h8,  4'h7,  1'b1, 8'hC8,  "sm8x7");
    run4(4'h7,  4'hF,  1'b1, 8'hF9,  "s7xm1");
    run4(4'hF,  4'hF,  1'b1, 8'h01,  "sm1xm1");
    run4(4'h5,  4'hB,  1'b1, 8'hE7,  "s5xm5");
    run4(4'h0,  4'hD,  1'b1, 8'h00,  "s0xm3");

    // full WIDTH=4 operand space, both modes
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), 1'b0, 8'(i * j), "exh_u");
      end
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        sp = 8'(i - ((i >= 8) ? 16 : 0)) * 8'(j - ((j >= 8) ? 16 : 0));
        run4(4'(i), 4'(j), 1'b1, 8'(sp), "exh_s");
      end
    end

    // WIDTH=8 corners
    run8(8'd255, 8'd255, 1'b0, 16'hFE01, "w8_u255x255");
    run8(8'h80,  8'h80,  1'b1, 16'h4000, "w8_sm128xm128");
    run8(8'h80,  8'h7F,  1'b1, 16'hC080, "w8_sm128x127");
    run8(8'd0,   8'd200, 1'b0, 16'h0000, "w8_0x200");

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
